// File: rtl/fact_accel_pkg.sv
// Shared constants for the factorial accelerator:
// register map, FSM encoding and operand limit.
package fact_accel_pkg;

  localparam int unsigned DW = 32;

  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  localparam logic [3:0] MAX_N = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic n_legal(input logic [3:0] n);
    return n <= MAX_N;
  endfunction

endpackage

// File: rtl/fact_datapath.sv
// Factorial datapath: running product, down-counter,
// 32-bit multiplier and end-of-count comparator.
module fact_datapath
  import fact_accel_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [3:0]    n_i,
  output logic [DW-1:0] product_o,
  output logic          last_o
);

  logic [DW-1:0] product_q, product_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] mul;

  assign mul       = product_q * {28'b0, cnt_q};
  assign last_o    = cnt_q <= 4'd1;
  assign product_o = product_q;

  // Load seeds the product; each step folds in cnt and counts down.
  always_comb begin
    product_d = product_q;
    cnt_d     = cnt_q;
    unique case (1'b1)
      load_i: begin
        product_d = 32'd1;
        cnt_d     = n_i;
      end
      (step_i && !last_o): begin
        product_d = mul;
        cnt_d     = cnt_q - 4'd1;
      end
      default: ;
    endcase
  end

  // Product and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: bus register
// file, control FSM and datapath instance.
module fact_accel
  import fact_accel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        busy,
  output logic        done
);

  state_e        state_q, state_d;
  logic [3:0]    n_q, n_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] result_q, result_d;

  logic          wr_n;
  logic          go;
  logic          load;
  logic          step;
  logic [DW-1:0] product;
  logic          last;
  logic          unused_wd;

  assign unused_wd = ^wd[31:4];

  assign busy = state_q == S_CALC;
  assign done = done_q;

  assign wr_n = we && (a == ADDR_N) && !busy;
  assign go   = we && (a == ADDR_GO) && wd[0] && !busy;

  // Operand register update.
  always_comb begin
    n_d = n_q;
    if (wr_n) n_d = wd[3:0];
  end

  // Control FSM: next state, status and datapath strobes.
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          if (n_legal(n_q)) begin
            state_d = S_CALC;
            done_d  = 1'b0;
            err_d   = 1'b0;
            load    = 1'b1;
          end else begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            err_d    = 1'b1;
            result_d = '0;
          end
        end
      end
      S_CALC: begin
        if (last) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = product;
        end else begin
          step = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Read mux reflects the registers as they were before this edge.
  always_comb begin
    rd = '0;
    unique case (1'b1)
      (a == ADDR_N):      rd = {28'b0, n_q};
      (a == ADDR_GO):     rd = {31'b0, busy};
      (a == ADDR_STATUS): rd = {30'b0, err_q, done_q};
      (a == ADDR_RESULT): rd = result_q;
      default: ;
    endcase
  end

  fact_datapath u_dp (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .n_i       (n_q),
    .product_o (product),
    .last_o    (last)
  );

endmodule

// File: tb/tb_fact_accel.sv
// Scoreboard bench for fact_accel with a
// factorial reference model.
module tb_fact_accel;
  import fact_accel_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          go_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_res = 0;

  fact_accel dut (
    .clk  (clk),
    .rst  (rst_n),
    .we   (we),
    .a    (a),
    .wd   (wd),
    .rd   (rd),
    .busy (busy),
    .done (done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fact_model(input int n);
    longint p = 1;
    if (n > 12) return 32'd0;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[31:0];
  endfunction

  function automatic int lat_model(input int n);
    if (n > 12) return 0;
    return (n < 2) ? 1 : n;
  endfunction

  // Completion monitor: pops one expectation per finished op.
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      if (busy && a == ADDR_RESULT)
        chk("result_hold", rd, last_res);
      if (done && !busy) begin
        mon_e = sb.pop_front();
        chk("latency", 32'(cyc - mon_e.go_cyc),
            32'(mon_e.lat));
        if (a == ADDR_RESULT)
          chk("result_mon", rd, mon_e.res);
        last_res = mon_e.res;
      end
    end
  end

  task automatic bus_write(input logic [1:0] ad,
                           input logic [31:0] d);
    we = 1; a = ad; wd = d;
    @(posedge clk); #1;
    we = 0; a = ADDR_RESULT; wd = $urandom();
  endtask

  task automatic read_chk(input logic [1:0] ad,
                          input logic [31:0] exp,
                          input string nm);
    a = ad;
    @(negedge clk);
    chk(nm, rd, exp);
    @(posedge clk); #1;
    a = ADDR_RESULT;
  endtask

  task automatic write_n(input int n);
    logic [31:0] r;
    r = $urandom();
    r[3:0] = 4'(n);
    bus_write(ADDR_N, r);
  endtask

  task automatic issue_go(input int n);
    logic [31:0] r;
    exp_t e;
    r = $urandom();
    r[0] = 1'b1;
    bus_write(ADDR_GO, r);
    e.res = fact_model(n);
    e.lat = lat_model(n);
    e.go_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #2;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout pending=%0d want=0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input int n);
    logic err;
    err = n > 12;
    write_n(n);
    issue_go(n);
    wait_sb();
    read_chk(ADDR_STATUS, {30'b0, err, 1'b1}, "status");
    read_chk(ADDR_RESULT, fact_model(n), "result_rd");
    read_chk(ADDR_N, 32'(n), "n_reg");
  endtask

  initial begin
    rst_n = 0; we = 0; a = ADDR_N; wd = 0;
    #3;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_n_rd", rd, 0);
    @(posedge clk); #1;
    rst_n = 1;
    read_chk(ADDR_GO, 0, "rst_go_rd");
    read_chk(ADDR_STATUS, 0, "rst_status");
    read_chk(ADDR_RESULT, 0, "rst_result");

    run_op(5);
    run_op(0);
    run_op(1);
    run_op(12);
    run_op(13);

    // GO with bit0 clear must not start anything.
    write_n(4);
    bus_write(ADDR_GO, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("go_bit0_busy", {31'b0, busy}, 0);
    @(posedge clk); #1;
    read_chk(ADDR_STATUS, 32'h3, "go_bit0_status");
    run_op(4);

    // Writes to STATUS/RESULT are ignored.
    bus_write(ADDR_RESULT, 32'hDEAD_BEEF);
    bus_write(ADDR_STATUS, 32'h0);
    read_chk(ADDR_RESULT, 32'h18, "ro_result");
    read_chk(ADDR_STATUS, 32'h1, "ro_status");

    // Read in the same cycle as an N write sees old value.
    we = 1; a = ADDR_N; wd = 32'd9;
    @(negedge clk);
    chk("rdw_old_n", rd, 32'd4);
    @(posedge clk); #1;
    we = 0; a = ADDR_RESULT;
    read_chk(ADDR_N, 32'd9, "rdw_new_n");

    // Writes while busy are ignored.
    write_n(6);
    issue_go(6);
    @(posedge clk); #1;
    write_n(3);
    bus_write(ADDR_GO, 32'h1);
    wait_sb();
    read_chk(ADDR_N, 32'd6, "busy_n_kept");
    read_chk(ADDR_RESULT, 32'h2D0, "busy_result");

    // Reset in the middle of a computation.
    write_n(10);
    issue_go(10);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    sb.delete();
    last_res = 0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_result", rd, 0);
    a = ADDR_N; #1;
    chk("midrst_n", rd, 0);
    a = ADDR_STATUS; #1;
    chk("midrst_status", rd, 0);
    a = ADDR_RESULT;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("post_rst_busy", {31'b0, busy}, 0);
      chk("post_rst_result", rd, 0);
    end
    @(posedge clk); #1;

    // Randomized operands, including illegal ones.
    for (int k = 0; k < 24; k++)
      run_op(int'($urandom_range(0, 15)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
